// File: rtl/latch_8_bit_if.sv
// Byte-wide capture/hold bus: data and enable in, held value out.
interface latch_8_bit_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             latch_en;
  logic [WIDTH-1:0] data_out;

  // Producer side: supplies data and the capture enable, observes the held value.
  modport master (
    output data_in,
    output latch_en,
    input  data_out
  );

  // Holding register side.
  modport slave (
    input  data_in,
    input  latch_en,
    output data_out
  );
endinterface

// File: rtl/latch_8_bit.sv
// Enable-controlled holding register: a clocked stand-in for a transparent
// latch. data_out comes straight from the register, so downstream logic never
// sees a combinational path from data_in or latch_en.
module latch_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  latch_8_bit_if.slave bus
);

  logic [WIDTH-1:0] data_q;

  // Capture on an enabled edge, otherwise hold; async reset clears the value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (bus.latch_en) begin
      data_q <= bus.data_in;
    end
  end

  assign bus.data_out = data_q;

endmodule

// File: tb/tb_latch_8_bit.sv
// Scoreboarded bench for latch_8_bit: the driver updates a reference value
// after each clock edge and queues it; the monitor checks the output on the
// following falling edge.
module tb_latch_8_bit;

  typedef struct {
    logic [7:0] val;
    string      name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];
  logic [7:0] model;

  latch_8_bit_if #(.WIDTH(8)) bus ();

  latch_8_bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one queued expectation per falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.data_out !== e.val) begin
        errors++;
        $display("FAIL %s: data_out=%h expected=%h at %0t", e.name, bus.data_out, e.val, $time);
      end
    end
  end

  // Immediate (non-scoreboard) comparison for asynchronous behaviour.
  task automatic check_now(input string name, input logic [7:0] want);
    checks++;
    if (bus.data_out !== want) begin
      errors++;
      $display("FAIL %s: data_out=%h expected=%h at %0t", name, bus.data_out, want, $time);
    end
  endtask

  // Drive one cycle of stimulus, let the edge happen, then queue the result
  // the register should show: reset gives zero, enable copies, else unchanged.
  task automatic cycle(input logic en, input logic [7:0] din, input string name);
    exp_t e;
    bus.latch_en = en;
    bus.data_in  = din;
    @(posedge clk);
    #1;
    if (!rst_n)  model = 8'h00;
    else if (en) model = din;
    e.val  = model;
    e.name = name;
    sb.push_back(e);
  endtask

  initial begin
    logic [7:0] hold_pat [3];
    logic [7:0] stream   [4];
    checks = 0;
    errors = 0;
    model  = 8'h00;
    hold_pat = '{8'h3C, 8'h00, 8'hFF};
    stream   = '{8'h01, 8'h02, 8'h04, 8'h80};

    // Power-up reset with capture requested: reset must win.
    rst_n        = 1'b0;
    bus.latch_en = 1'b1;
    bus.data_in  = 8'hFF;
    #1;
    check_now("reset_initial", 8'h00);
    repeat (3) cycle(1'b1, 8'hFF, "reset_hold");
    // Release away from the edge (externally synchronised).
    rst_n = 1'b1;

    // Single capture; the preceding falling edge checks it is not early.
    cycle(1'b1, 8'hA5, "capture");

    // Hold while data_in moves.
    for (int i = 0; i < 5; i++) cycle(1'b0, hold_pat[i % 3], "hold");

    // Streaming captures.
    for (int i = 0; i < 4; i++) cycle(1'b1, stream[i], "stream");

    // Async reset mid-hold.
    cycle(1'b1, 8'h5A, "load_5a");
    cycle(1'b0, 8'hC3, "hold_5a");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("async_reset", 8'h00);
    model = 8'h00;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h77, "post_reset_hold");

    // Randomised enable/data words.
    for (int i = 0; i < 32; i++) begin
      logic [8:0] w;
      w = 9'($urandom_range(0, 511));
      cycle(w[8], w[7:0], "random");
    end

    // Drain the scoreboard with a bounded wait.
    bus.latch_en = 1'b0;
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
